rv32_mod_core_sequencer: RTL
============================

RV32_MOD_CORE_SEQUENCER -- requirements
Module: rv32_mod_core_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of bus-wait cycles without ack before a trap (legal range 2..255).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 run  in  1  fetch enable; no new fetch is issued while 0.
REQ-004 dec_rf_write0_enable  in  1; dec_ram_req  in  4; dec_ram_wr  in  1; dec_br_is_cond  in  1; dec_br_jmp  in  1; dec_illegal  in  1 -- decoder control for the current instruction.
REQ-005 br_taken  in  1  branch comparator result.
REQ-006 bus_req  out  1; bus_wr  out  1; bus_size  out  4; bus_addr_sel  out  1 (0=PC, 1=ALU result); bus_ack  in  1; bus_err  in  1 -- single shared memory port.
REQ-007 ir_load  out  1; lsu_load  out  1; rf_write0  out  1; pc_load  out  1; pc_sel_target  out  1 (0=PC+4, 1=ALU target) -- datapath strobes.
REQ-008 state  out  3  current state; trap  out  1  sticky fault; retire  out  1  instruction-complete pulse; instret  out  32  retired-instruction count.

Function
REQ-009 SHALL implement the states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5; codes 6 and 7 SHALL go to TRAP on the next clock.
REQ-010 FETCH: while run=1, drive bus_req=1, bus_wr=0, bus_size=4'b0010, bus_addr_sel=0; with run=0 no request is issued and the state holds.
REQ-011 FETCH: on bus_ack=1 with bus_err=0, pulse ir_load for that cycle and go to DECODE.
REQ-012 Once bus_req is raised in FETCH or MEM, it SHALL stay high, with bus_wr, bus_size and bus_addr_sel stable, until ack, err or timeout; run=0 SHALL NOT withdraw it.
REQ-013 DECODE: one cycle, then EXECUTE.
REQ-014 EXECUTE: one cycle; dec_illegal=1 goes to TRAP; else dec_ram_req!=0 goes to MEM; else goes to WRITEBACK.
REQ-015 MEM: bus_req=1, bus_addr_sel=1, bus_wr=dec_ram_wr, bus_size=dec_ram_req.
REQ-016 MEM: on ack, pulse lsu_load in the ack cycle when dec_ram_wr=0, then go to WRITEBACK.
REQ-017 WRITEBACK: one cycle with pc_load=1, rf_write0=dec_rf_write0_enable, pc_sel_target=dec_br_jmp|(dec_br_is_cond&br_taken), retire=1; then FETCH.
REQ-018 instret SHALL increment by 1 on each retire and wrap from 0xFFFFFFFF to 0.
REQ-019 Timeout counter: cleared on entry to FETCH or MEM, incremented each cycle with bus_req=1 and no ack or err.
REQ-020 When the timeout counter reaches TIMEOUT_CYCLES-1 without ack, go to TRAP on the next edge.
REQ-021 bus_err=1 in FETCH or MEM SHALL go to TRAP; bus_err and bus_ack asserted together SHALL be treated as err.
REQ-022 bus_ack or bus_err outside FETCH/MEM, or in FETCH with run=0 and no request, SHALL be ignored.
REQ-023 TRAP: trap=1, all bus and strobe outputs 0, the state held until reset.
REQ-024 All strobes (ir_load, lsu_load, rf_write0, pc_load, retire) SHALL be single-cycle; the minimum ALU-instruction latency is 4 cycles (FETCH-ack to WRITEBACK inclusive) and a load/store takes at least 5.

Reset
REQ-025 rst_n=0 SHALL immediately force state=FETCH, trap=0, instret=0, timeout counter=0, and every output to 0, including bus_req mid-transaction.
REQ-026 After rst_n deasserts, the first FETCH request SHALL be raised combinationally in the first cycle with run=1.

Verification
REQ-027 ADD (ram_req=0, rf_we=1), ack on the 1st request cycle -> states 0,1,2,4,0; rf_write0=1 and retire=1 in WRITEBACK; instret=1.
REQ-028 Load (ram_req=4'b0010, wr=0), ack delayed 3 cycles in MEM -> bus_addr_sel=1 held 4 cycles; lsu_load pulses once; then WRITEBACK.
REQ-029 Taken branch (is_cond=1, br_taken=1) -> pc_sel_target=1 with pc_load=1; not-taken -> pc_sel_target=0.
REQ-030 No ack for 16 cycles in FETCH (default parameter) -> TRAP; trap=1 and bus_req=0 until rst_n pulse.
REQ-031 ack=err=1 in MEM -> TRAP with no lsu_load; rst_n low mid-MEM -> bus_req=0 in the same cycle and state=0.
REQ-032 instret preloaded via 0xFFFFFFFF retires -> next retire gives instret=0 (backdoor force acceptable).

Source files
------------

// File: rtl/rv32_mod_core_sequencer.sv
// Multi-cycle control sequencer for a small RV32 core: walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// over one shared memory port, traps on bus error, bus timeout or illegal instruction.
module rv32_mod_core_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        dec_rf_write0_enable,
    input  logic [3:0]  dec_ram_req,
    input  logic        dec_ram_wr,
    input  logic        dec_br_is_cond,
    input  logic        dec_br_jmp,
    input  logic        dec_illegal,
    input  logic        br_taken,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_size,
    output logic        bus_addr_sel,
    input  logic        bus_ack,
    input  logic        bus_err,
    output logic        ir_load,
    output logic        lsu_load,
    output logic        rf_write0,
    output logic        pc_load,
    output logic        pc_sel_target,
    output logic [2:0]  state,
    output logic        trap,
    output logic        retire,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic        r_req_active;
    logic [7:0]  r_tmo;
    logic [31:0] r_instret;

    logic w_bus_req;
    logic w_ack;
    logic w_err;
    logic w_timeout;

    // A fetch request, once raised, is held by r_req_active even if run drops.
    assign w_bus_req = rst_n & (((r_state == ST_FETCH) & (run | r_req_active)) |
                                (r_state == ST_MEM));
    assign w_err     = w_bus_req & bus_err;
    assign w_ack     = w_bus_req & bus_ack & ~bus_err;
    assign w_timeout = w_bus_req & ~bus_ack & ~bus_err & (r_tmo == TMO_LAST);

    assign state   = r_state;
    assign instret = r_instret;
    assign bus_req = w_bus_req;

    always_comb begin
        // NOTE: every output gets a default before the case, otherwise unassigned paths infer latches.
        bus_wr        = 1'b0;
        bus_size      = 4'b0000;
        bus_addr_sel  = 1'b0;
        ir_load       = 1'b0;
        lsu_load      = 1'b0;
        rf_write0     = 1'b0;
        pc_load       = 1'b0;
        pc_sel_target = 1'b0;
        retire        = 1'b0;
        trap          = 1'b0;
        // Outputs are decoded from state, so they are gated by rst_n to read zero during reset.
        if (rst_n) begin
            case (r_state)
                ST_FETCH: begin
                    if (w_bus_req) bus_size = 4'b0010;
                    ir_load = w_ack;
                end
                ST_MEM: begin
                    bus_wr       = dec_ram_wr;
                    bus_size     = dec_ram_req;
                    bus_addr_sel = 1'b1;
                    lsu_load     = w_ack & ~dec_ram_wr;
                end
                ST_WRITEBACK: begin
                    pc_load       = 1'b1;
                    rf_write0     = dec_rf_write0_enable;
                    pc_sel_target = dec_br_jmp | (dec_br_is_cond & br_taken);
                    retire        = 1'b1;
                end
                ST_TRAP: trap = 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_req_active <= 1'b0;
            r_tmo        <= 8'd0;
            r_instret    <= 32'd0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_err || w_timeout) begin
                        r_state      <= ST_TRAP;
                        r_req_active <= 1'b0;
                    end else if (w_ack) begin
                        r_state      <= ST_DECODE;
                        r_req_active <= 1'b0;
                        r_tmo        <= 8'd0;
                    end else if (w_bus_req) begin
                        r_req_active <= 1'b1;
                        r_tmo        <= r_tmo + 8'd1;
                    end
                end
                ST_DECODE: r_state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (dec_illegal) begin
                        r_state <= ST_TRAP;
                    end else if (dec_ram_req != 4'd0) begin
                        r_state <= ST_MEM;
                        r_tmo   <= 8'd0;
                    end else begin
                        r_state <= ST_WRITEBACK;
                    end
                end
                ST_MEM: begin
                    if (w_err || w_timeout) r_state <= ST_TRAP;
                    else if (w_ack)         r_state <= ST_WRITEBACK;
                    else                    r_tmo   <= r_tmo + 8'd1;
                end
                ST_WRITEBACK: begin
                    r_state   <= ST_FETCH;
                    r_tmo     <= 8'd0;
                    r_instret <= r_instret + 32'd1;
                end
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_TRAP;
            endcase
        end
    end

endmodule
